// File: rtl/boa_pmu_sequencer.sv
// ---------------------------------------------------------------------------
// boa_pmu_sequencer
//   Power/reset sequencer between the CPU-side PMU register and the board
//   power/reset pins. Sequences power-up, reset hold, run, graceful (button)
//   and forced shutdown and brownout recovery, and records the last reset cause.
//
//   Optional feature macro: BOA_PMU_WDT_EN
//     Adds the wdt_kick input and a watchdog that resets the system from
//     RUN/SHDN_WAIT (cause code 4) when it is not kicked for WDT_TIMEOUT cycles.
//
//   Ports
//     clk          in   CPU clock
//     rst          in   asynchronous active-high reset (full power-on sequence)
//     req_rst      in   software reset request, 1-cycle pulse
//     req_shdn     in   software shutdown request, 1-cycle pulse
//     btn          in   raw power button, async, active-high
//     pwr_good     in   rail good, async
//     wdt_kick     in   watchdog kick (BOA_PMU_WDT_EN only)
//     pwr_en       out  rail enable
//     sys_rst      out  system reset
//     shdn_pending out  shutdown-pending interrupt
//     state        out  FSM state code
//     last_cause   out  0 power-on, 1 software, 2 button, 3 brownout, 4 watchdog
// ---------------------------------------------------------------------------
module boa_pmu_sequencer #(
   parameter int PWRUP_DELAY  = 64,
   parameter int RST_HOLD     = 16,
   parameter int SHDN_DELAY   = 1024,
   parameter int DEBOUNCE_CYC = 1000
`ifdef BOA_PMU_WDT_EN
   ,parameter int WDT_TIMEOUT = 65536
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_rst,
   input  logic       req_shdn,
   input  logic       btn,
   input  logic       pwr_good,
`ifdef BOA_PMU_WDT_EN
   input  logic       wdt_kick,
`endif
   output logic       pwr_en,
   output logic       sys_rst,
   output logic       shdn_pending,
   output logic [2:0] state,
   output logic [2:0] last_cause
);

   localparam int MAX_A = (PWRUP_DELAY > RST_HOLD) ? PWRUP_DELAY : RST_HOLD;
   localparam int MAX_D = (MAX_A > SHDN_DELAY) ? MAX_A : SHDN_DELAY;
   localparam int CNT_W = $clog2(MAX_D + 1);
   localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);

   localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_DELAY - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD - 1);
   localparam logic [CNT_W-1:0] SHDN_LAST  = CNT_W'(SHDN_DELAY - 1);
   localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYC - 1);
   localparam logic [DEB_W-1:0] DEB_MAX    = DEB_W'(DEBOUNCE_CYC);

   typedef enum logic [2:0] {
      S_OFF       = 3'd0,
      S_PWRUP     = 3'd1,
      S_RESET     = 3'd2,
      S_RUN       = 3'd3,
      S_SHDN_WAIT = 3'd4,
      S_SHDN      = 3'd5
   } state_t;

   localparam logic [2:0] C_POR   = 3'd0;
   localparam logic [2:0] C_SW    = 3'd1;
   localparam logic [2:0] C_BTN   = 3'd2;
   localparam logic [2:0] C_BROWN = 3'd3;
   localparam logic [2:0] C_WDT   = 3'd4;

   state_t           state_q, state_d;
   logic [2:0]       cause_q, cause_d;
   logic             cold_q, cold_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DEB_W-1:0] deb_q, deb_d;
   logic             pwr_en_q, pwr_en_d;
   logic             sys_rst_q, sys_rst_d;
   logic             pend_q, pend_d;
   logic             btn_meta_q, btn_sync_q;
   logic             pg_meta_q, pg_sync_q;
   logic             press;
   logic             active;
   logic             wdt_fire;

   // Debounce: the count saturates at DEBOUNCE_CYC, so exactly one press
   // pulse fires per high period; a new one needs btn to drop to 0 first.
   always_comb begin
      deb_d = '0;
      if (btn_sync_q)
         deb_d = (deb_q == DEB_MAX) ? deb_q : deb_q + 1'b1;
   end
   assign press  = btn_sync_q && (deb_q == DEB_LAST);
   assign active = (state_q == S_RUN) || (state_q == S_SHDN_WAIT);

`ifdef BOA_PMU_WDT_EN
   localparam int WDT_W = $clog2(WDT_TIMEOUT + 1);
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_TIMEOUT - 1);
   logic [WDT_W-1:0] wdt_q, wdt_d;

   assign wdt_fire = active && !wdt_kick && (wdt_q == WDT_LAST);

   always_comb begin
      wdt_d = (wdt_q == '1) ? wdt_q : wdt_q + 1'b1;
      if (wdt_kick || !active || (state_d != state_q))
         wdt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wdt_q <= '0;
      else     wdt_q <= wdt_d;
   end
`else
   assign wdt_fire = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      cold_d  = cold_q;
      cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

      case (state_q)
         S_OFF: begin
            if (cold_q) begin
               state_d = S_PWRUP;
               cold_d  = 1'b0;
               cause_d = C_POR;
            end else if (press) begin
               state_d = S_PWRUP;
               cause_d = C_BTN;
            end
         end
         S_PWRUP: begin
            // Counts only consecutive cycles of good rail.
            if (!pg_sync_q)
               cnt_d = '0;
            else if (cnt_q == PWRUP_LAST)
               state_d = S_RESET;
         end
         S_RESET: begin
            if (cnt_q == HOLD_LAST)
               state_d = S_RUN;
         end
         S_RUN: begin
            if (!pg_sync_q) begin
               state_d = S_PWRUP;
               cause_d = C_BROWN;
            end else if (wdt_fire) begin
               state_d = S_RESET;
               cause_d = C_WDT;
            end else if (req_shdn) begin
               state_d = S_SHDN;
            end else if (req_rst) begin
               state_d = S_RESET;
               cause_d = C_SW;
            end else if (press) begin
               state_d = S_SHDN_WAIT;
            end
         end
         S_SHDN_WAIT: begin
            if (!pg_sync_q) begin
               state_d = S_PWRUP;
               cause_d = C_BROWN;
            end else if (wdt_fire) begin
               state_d = S_RESET;
               cause_d = C_WDT;
            end else if (req_shdn || (cnt_q == SHDN_LAST)) begin
               state_d = S_SHDN;
            end else if (req_rst) begin
               state_d = S_RESET;
               cause_d = C_SW;
            end
         end
         S_SHDN: begin
            if (cnt_q == HOLD_LAST)
               state_d = S_OFF;
         end
         default: state_d = S_OFF;
      endcase

      if (state_d != state_q)
         cnt_d = '0;

      // Outputs are registered from the next state so they line up with state.
      pwr_en_d  = (state_d == S_PWRUP) || (state_d == S_RESET) ||
                  (state_d == S_RUN)   || (state_d == S_SHDN_WAIT);
      sys_rst_d = !((state_d == S_RUN) || (state_d == S_SHDN_WAIT));
      pend_d    = (state_d == S_SHDN_WAIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_meta_q <= 1'b0;
         btn_sync_q <= 1'b0;
         pg_meta_q  <= 1'b0;
         pg_sync_q  <= 1'b0;
         state_q    <= S_OFF;
         cause_q    <= C_POR;
         cold_q     <= 1'b1;
         cnt_q      <= '0;
         deb_q      <= '0;
         pwr_en_q   <= 1'b0;
         sys_rst_q  <= 1'b1;
         pend_q     <= 1'b0;
      end else begin
         btn_meta_q <= btn;
         btn_sync_q <= btn_meta_q;
         pg_meta_q  <= pwr_good;
         pg_sync_q  <= pg_meta_q;
         state_q    <= state_d;
         cause_q    <= cause_d;
         cold_q     <= cold_d;
         cnt_q      <= cnt_d;
         deb_q      <= deb_d;
         pwr_en_q   <= pwr_en_d;
         sys_rst_q  <= sys_rst_d;
         pend_q     <= pend_d;
      end
   end

   // Brownout bypasses the output register so the CPU is held in reset
   // in the same cycle the rail drop is seen.
   assign sys_rst      = sys_rst_q || (active && !pg_sync_q);
   assign pwr_en       = pwr_en_q;
   assign shdn_pending = pend_q;
   assign state        = state_q;
   assign last_cause   = cause_q;

endmodule
